// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and the
// control-register bit positions used by both the register file and the line engines.
package uart_tx_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    // Control register bit indices
    localparam int unsigned UART_EN   = 0;
    localparam int unsigned STOP      = 1;
    localparam int unsigned PARITY    = 2;
    localparam int unsigned PARITY_EN = 3;
    localparam int unsigned TX_EN     = 4;
    localparam int unsigned RX_EN     = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Ports:
//   clock        system clock
//   reset        synchronous active-low reset
//   period       bit period minus one, in clocks
//   clear        hold the count at zero
//   bit_end      high in the last clock of the current bit period
//   bit_end_next high when the following clock will be the last of a bit period
module uart_baud_gen (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] period,
    input  logic        clear,
    output logic        bit_end,
    output logic        bit_end_next
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || (cnt_q == period)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end      = (cnt_q == period);
    // Lets the owner register a strobe that lines up with bit_end.
    assign bit_end_next = (cnt_d == period);

endmodule

// File: rtl/uart_tx.sv
// UART serial transmit engine. Pops bytes from the TX FIFO and sends
// start, DATA_BITS data bits (LSB first), optional parity and 1 or 2 stop bits.
// Ports:
//   clock, reset                  system clock, synchronous active-low reset
//   uart_en, tx_en                global and transmitter enables
//   parity_enable, parity         parity present; 0 = even, 1 = odd
//   stop_bit                      0 = one stop bit, 1 = two
//   baud_rate                     bit period minus one, in clocks
//   tx_fifo_empty, tx_fifo_rdata  FIFO status and read data (valid the cycle after a pop)
//   tx_fifo_rd_en                 one-cycle pop strobe
//   tx, busy, tx_done             serial line, frame in progress, end-of-frame pulse
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_en,
    input  logic                 tx_en,
    input  logic                 parity_enable,
    input  logic                 parity,
    input  logic                 stop_bit,
    input  logic [15:0]          baud_rate,
    input  logic                 tx_fifo_empty,
    input  logic [DATA_BITS-1:0] tx_fifo_rdata,
    output logic                 tx_fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CntW-1:0] LastData = CntW'(DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 stop_q, stop_d;
    logic [15:0]          baud_q, baud_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 rd_en_q, rd_en_d;
    logic                 done_q, done_d;

    logic baud_clear;
    logic bit_end;
    logic bit_end_next;

    assign baud_clear = (state_q == StIdle) || (state_q == StLoad);

    uart_baud_gen u_baud_gen (
        .clock        (clock),
        .reset        (reset),
        .period       (baud_q),
        .clear        (baud_clear),
        .bit_end      (bit_end),
        .bit_end_next (bit_end_next)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        stop_d    = stop_q;
        baud_d    = baud_q;
        par_d     = par_q;

        unique case (state_q)
            StIdle: begin
                // Pop was issued last cycle; its data arrives during LOAD.
                if (rd_en_q && uart_en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shift_d   = tx_fifo_rdata;
                par_en_d  = parity_enable;
                stop_d    = stop_bit;
                baud_d    = baud_rate;
                par_d     = (^tx_fifo_rdata) ^ parity;
                bit_cnt_d = '0;
                state_d   = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_cnt_q == CntW'(stop_q)) begin
                        state_d = StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Disabling the UART drops the frame in flight.
        if (!uart_en && (state_q != StIdle)) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
        end

        // Outputs are registered, so they are derived from the next state.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d  = (state_d != StIdle);
        rd_en_d = (state_d == StIdle) && !rd_en_q && uart_en && tx_en && !tx_fifo_empty;
        done_d  = (state_d == StStop) && bit_end_next && (bit_cnt_d == CntW'(stop_d));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            stop_q    <= 1'b0;
            baud_q    <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            stop_q    <= stop_d;
            baud_q    <= baud_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
        end
    end

    assign tx            = tx_q;
    assign busy          = busy_q;
    assign tx_fifo_rd_en = rd_en_q;
    assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes FIFO bytes with their expected
// line frames; a monitor checks every frame cycle by cycle as the DUT pops and sends it.
module tb_uart_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        uart_en;
    logic        tx_en;
    logic        parity_enable;
    logic        parity;
    logic        stop_bit;
    logic [15:0] baud_rate;
    logic        tx_fifo_empty;
    logic [7:0]  tx_fifo_rdata = 8'h00;
    logic        tx_fifo_rd_en;
    logic        tx;
    logic        busy;
    logic        tx_done;

    always #5 clock = ~clock;

    uart_tx #(
        .DATA_BITS (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_en       (uart_en),
        .tx_en         (tx_en),
        .parity_enable (parity_enable),
        .parity        (parity),
        .stop_bit      (stop_bit),
        .baud_rate     (baud_rate),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_rdata (tx_fifo_rdata),
        .tx_fifo_rd_en (tx_fifo_rd_en),
        .tx            (tx),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    // FIFO model: written by stimulus, read on pop
    logic [7:0] fifo_mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign tx_fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clock) begin
        if (tx_fifo_rd_en === 1'b1 && rd_ptr != wr_ptr) begin
            tx_fifo_rdata <= fifo_mem[rd_ptr % 16];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // bits[i] is the i-th symbol on the line; baud is clocks per bit minus one;
    // cut != 0 means the frame is cut off after that many line cycles.
    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          baud;
        int          cut;
        bit          b2b;
    } frame_t;

    frame_t exp_q[$];
    int total = 0;
    int bad = 0;
    int pops = 0;
    int frames_done = 0;
    int frames_pushed = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] data, input logic [11:0] bits,
                              input int nbits, input int baud, input int cut, input bit b2b);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        f.baud  = baud;
        f.cut   = cut;
        f.b2b   = b2b;
        exp_q.push_back(f);
        frames_pushed++;
        fifo_mem[wr_ptr % 16] = data;
        wr_ptr++;
    endtask

    task automatic set_cfg(input bit pe, input bit par, input bit sb, input logic [15:0] br);
        parity_enable = pe;
        parity        = par;
        stop_bit      = sb;
        baud_rate     = br;
    endtask

    task automatic wait_frames(input int budget);
        int n;
        n = 0;
        while (frames_done < frames_pushed && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(frames_done >= frames_pushed, "frames_timeout", 32'(frames_done),
            32'(frames_pushed));
    endtask

    task automatic wait_pop(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (tx_fifo_rd_en !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tx_fifo_rd_en === 1'b1, "pop_timeout", 32'(tx_fifo_rd_en), 32'd1);
    endtask

    // Monitor: one scoreboard entry per pop
    initial begin : monitor
        frame_t e;
        bit     have_pop;
        bit     bit_ok;
        logic   want;
        int     per;
        int     lim;
        int     total_cyc;
        int     done_cnt;
        int     done_at;
        have_pop = 1'b0;
        forever begin
            if (!have_pop) begin
                @(negedge clock);
                while (tx_fifo_rd_en !== 1'b1) @(negedge clock);
            end
            have_pop = 1'b0;
            pops++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_pop", 32'd1, 32'd0);
                continue;
            end
            e = exp_q.pop_front();
            @(negedge clock);
            chk(tx === 1'b1 && busy === 1'b1 && tx_fifo_rd_en === 1'b0, "load_cycle",
                32'({tx, busy, tx_fifo_rd_en}), 32'b110);
            per       = e.baud + 1;
            total_cyc = e.nbits * per;
            lim       = (e.cut != 0) ? e.cut : total_cyc;
            done_cnt  = 0;
            done_at   = -1;
            bit_ok    = 1'b1;
            for (int k = 0; k < lim; k++) begin
                @(negedge clock);
                want = e.bits[k / per];
                if (k % per == 0) bit_ok = 1'b1;
                if (tx !== want || busy !== 1'b1 || tx_fifo_rd_en !== 1'b0) bit_ok = 1'b0;
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    done_at = k;
                end
                if (k % per == per - 1 || k == lim - 1) begin
                    chk(bit_ok, $sformatf("frame%0d_bit%0d", frames_done, k / per),
                        32'(tx), 32'(want));
                end
            end
            if (e.cut == 0) begin
                chk(done_cnt == 1 && done_at == total_cyc - 1, "tx_done_position",
                    32'(done_at), 32'(total_cyc - 1));
            end else begin
                chk(done_cnt == 0, "tx_done_after_abort", 32'(done_cnt), 32'd0);
            end
            @(negedge clock);
            chk(tx === 1'b1 && busy === 1'b0 && tx_done === 1'b0 && tx_fifo_rd_en === e.b2b,
                "post_frame", 32'({tx, busy, tx_done, tx_fifo_rd_en}),
                32'({1'b1, 1'b0, 1'b0, e.b2b}));
            have_pop = (tx_fifo_rd_en === 1'b1);
            frames_done++;
        end
    end

    initial begin : stim
        bit saw;
        reset   = 1'b0;
        uart_en = 1'b0;
        tx_en   = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 16'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk(tx === 1'b1 && busy === 1'b0 && tx_fifo_rd_en === 1'b0 && tx_done === 1'b0,
            "reset_state", 32'({tx, busy, tx_fifo_rd_en, tx_done}), 32'b1000);
        @(posedge clock);
        #1;
        reset   = 1'b1;
        uart_en = 1'b1;
        tx_en   = 1'b1;

        // 8N1, 4 clocks per bit
        set_cfg(1'b0, 1'b0, 1'b0, 16'd3);
        push_frame(8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 3, 0, 1'b0);
        wait_frames(200);

        // 8E1 then 8O1, 1 clock per bit; 0xA5 has four ones
        set_cfg(1'b1, 1'b0, 1'b0, 16'd0);
        push_frame(8'hA5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0, 0, 1'b0);
        wait_frames(100);
        set_cfg(1'b1, 1'b1, 1'b0, 16'd0);
        push_frame(8'hA5, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 0, 0, 1'b0);
        wait_frames(100);

        // 8N2 back-to-back
        set_cfg(1'b0, 1'b0, 1'b1, 16'd1);
        push_frame(8'h00, {1'b0, 2'b11, 8'h00, 1'b0}, 11, 1, 0, 1'b1);
        push_frame(8'hFF, {1'b0, 2'b11, 8'hFF, 1'b0}, 11, 1, 0, 1'b0);
        wait_frames(200);

        // Config change during DATA: first frame keeps 8N1/baud 3
        set_cfg(1'b0, 1'b0, 1'b0, 16'd3);
        push_frame(8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 3, 0, 1'b1);
        push_frame(8'hC3, {1'b0, 2'b11, 8'hC3, 1'b0}, 11, 7, 0, 1'b0);
        wait_pop(100);
        repeat (10) @(posedge clock);
        #1;
        stop_bit  = 1'b1;
        baud_rate = 16'd7;
        wait_frames(400);

        // uart_en dropped during data bit 3 (line cycles 16..19 of the frame)
        set_cfg(1'b0, 1'b0, 1'b0, 16'd3);
        push_frame(8'h96, {2'b00, 1'b1, 8'h96, 1'b0}, 10, 3, 18, 1'b0);
        push_frame(8'h69, {2'b00, 1'b1, 8'h69, 1'b0}, 10, 3, 0, 1'b0);
        wait_pop(100);
        repeat (19) @(posedge clock);
        #1;
        uart_en = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        uart_en = 1'b1;
        wait_frames(300);

        // Reset during the parity bit (line cycles 36..39); 0x5A and 0x11 have even ones
        set_cfg(1'b1, 1'b0, 1'b0, 16'd3);
        push_frame(8'h5A, {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 3, 38, 1'b0);
        wait_pop(100);
        repeat (39) @(posedge clock);
        #1;
        reset = 1'b0;
        push_frame(8'h11, {1'b0, 1'b1, 1'b0, 8'h11, 1'b0}, 11, 3, 0, 1'b0);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (tx_fifo_rd_en !== 1'b0) saw = 1'b1;
        end
        chk(!saw, "no_pop_in_reset", 32'(saw), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wait_frames(300);

        // tx_en low holds off the pop
        tx_en = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 16'd0);
        push_frame(8'h0F, {2'b00, 1'b1, 8'h0F, 1'b0}, 10, 0, 0, 1'b0);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (tx_fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) saw = 1'b1;
        end
        chk(!saw, "idle_while_tx_en_low", 32'(saw), 32'd0);
        @(posedge clock);
        #1;
        tx_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk(tx_fifo_rd_en === 1'b1, "pop_after_tx_en", 32'(tx_fifo_rd_en), 32'd1);
        wait_frames(100);

        repeat (4) @(negedge clock);
        chk(pops == 12, "pop_count", 32'(pops), 32'd12);
        chk(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
